full_adder: RTL and testbench

FULL_ADDER -- requirements
Module: full_adder

---
 rtl/full_adder_pkg.sv | 9 +
 rtl/full_adder_fa_cell.sv | 14 +
 rtl/full_adder.sv | 68 ++++++
 tb/tb_full_adder.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/full_adder_pkg.sv
// Shared helpers for the ripple-carry adder: the signed-overflow rule
// derived from the two most significant carries of the chain.
package full_adder_pkg;

    function automatic logic signed_ovf(input logic carry_into_msb, input logic carry_out);
        return carry_into_msb ^ carry_out;
    endfunction

endpackage

// File: rtl/full_adder_fa_cell.sv
// One-bit combinational full-adder cell; the ripple chain in full_adder
// is built from these. Holds no state.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic S,
    output logic C
);

    assign S = a ^ b ^ c;
    assign C = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder with carry-out, signed overflow
// and a one-cycle valid pipeline.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    input  logic             in_valid,
    output logic [WIDTH-1:0] S,
    output logic             C,
    output logic             V,
    output logic             out_valid
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_p0;
    logic             co_p0;
    logic             ov_p0;

    logic [WIDTH-1:0] sum_p1;
    logic             co_p1;
    logic             ov_p1;
    logic             vld_p1;

    // Stage 0: combinational ripple chain, LSB to MSB
    assign carry[0] = c;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        fa_cell u_cell (
            .a (a[i]),
            .b (b[i]),
            .c (carry[i]),
            .S (sum_p0[i]),
            .C (carry[i+1])
        );
    end

    assign co_p0 = carry[WIDTH];
    assign ov_p0 = signed_ovf(carry[WIDTH-1], carry[WIDTH]);

    // Stage 1: output register; data only loads on in_valid so idle inputs never disturb it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_p1 <= '0;
            co_p1  <= 1'b0;
            ov_p1  <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                sum_p1 <= sum_p0;
                co_p1  <= co_p0;
                ov_p1  <= ov_p0;
            end
        end
    end

    assign S         = sum_p1;
    assign C         = co_p1;
    assign V         = ov_p1;
    assign out_valid = vld_p1;

endmodule

// File: tb/tb_full_adder.sv
// Directed and randomized checks of full_adder at widths 1, 8 and 16.
module tb_full_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       a1, b1, c1, iv1;
    logic       s1, co1, v1, ov1;
    logic [7:0] a8, b8, s8;
    logic       c8, iv8, co8, v8, ov8;
    logic [15:0] a16, b16, s16;
    logic        c16, iv16, co16, v16, ov16;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    full_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1), .in_valid(iv1),
        .S(s1), .C(co1), .V(v1), .out_valid(ov1)
    );
    full_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .c(c8), .in_valid(iv8),
        .S(s8), .C(co8), .V(v8), .out_valid(ov8)
    );
    full_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .a(a16), .b(b16), .c(c16), .in_valid(iv16),
        .S(s16), .C(co16), .V(v16), .out_valid(ov16)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic a, b, c;
        logic eC, eS, eV;
    } vec1_t;

    typedef struct {
        logic [7:0] a, b;
        logic       c;
        logic [7:0] eS;
        logic       eC, eV;
    } vec8_t;

    vec1_t t1[8];
    vec8_t t8[6];

    logic [16:0] sum17;
    logic [15:0] exp_s;
    logic        exp_c, exp_v;

    initial begin
        t1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        t1[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        t1[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        t1[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        t1[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        t1[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        t1[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        t1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        t8[0] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        t8[1] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        t8[2] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        t8[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        t8[4] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
        t8[5] = '{8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1};

        a1 = 0; b1 = 0; c1 = 0; iv1 = 0;
        a8 = 0; b8 = 0; c8 = 0; iv8 = 0;
        a16 = 0; b16 = 0; c16 = 0; iv16 = 0;

        // reset state, held across an edge
        #12;
        chk("rst_w1", {s1, co1, v1, ov1}, 0);
        chk("rst_w8", {s8, co8, v8, ov8}, 0);
        chk("rst_w16", {s16, co16, v16, ov16}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // WIDTH=1 exhaustive, back to back
        for (int i = 0; i < 8; i++) begin
            a1 = t1[i].a; b1 = t1[i].b; c1 = t1[i].c; iv1 = 1'b1;
            step();
            chk($sformatf("w1_vec%0d", i), {co1, s1, v1, ov1},
                {t1[i].eC, t1[i].eS, t1[i].eV, 1'b1});
        end
        iv1 = 1'b0;

        // WIDTH=8 directed corners
        for (int i = 0; i < 6; i++) begin
            a8 = t8[i].a; b8 = t8[i].b; c8 = t8[i].c; iv8 = 1'b1;
            step();
            chk($sformatf("w8_vec%0d", i), {s8, co8, v8, ov8},
                {t8[i].eS, t8[i].eC, t8[i].eV, 1'b1});
        end

        // hold: capture then idle with unknown inputs
        a8 = 8'h10; b8 = 8'h20; c8 = 1'b0; iv8 = 1'b1;
        step();
        chk("hold_capture", {s8, co8, v8, ov8}, {8'h30, 1'b0, 1'b0, 1'b1});
        a8 = 'x; b8 = 'x; c8 = 1'bx; iv8 = 1'b0;
        step();
        chk("hold_idle1", {s8, co8, v8, ov8}, {8'h30, 1'b0, 1'b0, 1'b0});
        a8 = 8'hFF; b8 = 8'h01; c8 = 1'b1;
        step();
        chk("hold_idle2", {s8, co8, v8, ov8}, {8'h30, 1'b0, 1'b0, 1'b0});

        // asynchronous reset with a result in flight
        a8 = 8'h55; b8 = 8'hAA; c8 = 1'b1; iv8 = 1'b1;
        step();
        chk("pre_rst", {s8, co8, v8, ov8}, {8'h00, 1'b1, 1'b0, 1'b1});
        a8 = 8'h7F; b8 = 8'h7F; c8 = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_immediate", {s8, co8, v8, ov8}, 0);
        step();
        chk("rst_held_edge", {s8, co8, v8, ov8}, 0);
        rst = 1'b0;
        iv8 = 1'b0;
        step();
        chk("rst_no_pulse", {s8, co8, v8, ov8}, 0);
        a8 = 8'h03; b8 = 8'h04; c8 = 1'b0; iv8 = 1'b1;
        step();
        chk("first_after_rst", {s8, co8, v8, ov8}, {8'h07, 1'b0, 1'b0, 1'b1});
        iv8 = 1'b0;

        // WIDTH=16 random with random in_valid
        exp_s = 16'h0; exp_c = 1'b0; exp_v = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            a16 = 16'($urandom); b16 = 16'($urandom);
            c16 = 1'($urandom); iv16 = 1'($urandom);
            if (iv16) begin
                sum17 = {1'b0, a16} + {1'b0, b16} + {16'h0, c16};
                exp_s = sum17[15:0];
                exp_c = sum17[16];
                exp_v = (a16[15] == b16[15]) && (sum17[15] != a16[15]);
            end
            step();
            chk($sformatf("w16_rand%0d", i), {s16, co16, v16, ov16},
                {exp_s, exp_c, exp_v, iv16});
        end
        iv16 = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
